// File: rtl/rotor2_fwd.sv
// Rotor 2 forward (keyboard-to-reflector) path: position register with single/double stepping,
// forward wiring plus position offset, and a one-entry valid/ready output stage.
module rotor2_fwd #(
    parameter logic [4:0] NOTCH       = 5'd4,
    parameter bit         DOUBLE_STEP = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    input  logic       step_in,
    input  logic       set_en,
    input  logic [4:0] set_pos,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    output logic       out_err,
    output logic [4:0] pos,
    output logic       turnover_out
);

    // Forward wiring; unused codes map to 0 and are flagged as errors separately.
    function automatic logic [4:0] fwd_map(input logic [4:0] l);
        logic [4:0] r;
        case (l)
            5'd1:    r = 5'd6;
            5'd2:    r = 5'd15;
            5'd3:    r = 5'd11;
            5'd4:    r = 5'd21;
            5'd5:    r = 5'd4;
            5'd6:    r = 5'd1;
            5'd7:    r = 5'd26;
            5'd8:    r = 5'd14;
            5'd9:    r = 5'd17;
            5'd10:   r = 5'd16;
            5'd11:   r = 5'd24;
            5'd12:   r = 5'd23;
            5'd13:   r = 5'd2;
            5'd14:   r = 5'd10;
            5'd15:   r = 5'd9;
            5'd16:   r = 5'd5;
            5'd17:   r = 5'd8;
            5'd18:   r = 5'd3;
            5'd19:   r = 5'd13;
            5'd20:   r = 5'd19;
            5'd21:   r = 5'd7;
            5'd22:   r = 5'd12;
            5'd23:   r = 5'd18;
            5'd24:   r = 5'd25;
            5'd25:   r = 5'd20;
            5'd26:   r = 5'd22;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    logic [4:0] pos_q, pos_d;
    logic       valid_q, valid_d;
    logic [4:0] letter_q, letter_d;
    logic       err_q, err_d;
    logic       turn_q, turn_d;

    logic       acc;
    logic       step_hit;
    logic       letter_ok;
    logic [4:0] pos_inc;
    logic [5:0] sum;

    assign in_ready     = !valid_q || out_ready;
    assign acc          = in_valid && in_ready;
    assign out_valid    = valid_q;
    assign out_letter   = letter_q;
    assign out_err      = err_q;
    assign pos          = pos_q;
    assign turnover_out = turn_q;

    // Next-state: position update, encipher with the post-step position, output handshake.
    always_comb begin
        pos_d     = pos_q;
        valid_d   = valid_q;
        letter_d  = letter_q;
        err_d     = err_q;
        turn_d    = 1'b0;
        step_hit  = acc && (step_in || (DOUBLE_STEP && (pos_q == NOTCH)));
        pos_inc   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
        letter_ok = (in_letter != 5'd0) && (in_letter <= 5'd26);

        // A load always wins over stepping and never produces a turnover.
        if (set_en) begin
            pos_d = (set_pos > 5'd25) ? 5'd0 : set_pos;
        end else if (step_hit) begin
            pos_d  = pos_inc;
            turn_d = (pos_q == NOTCH);
        end

        sum = {1'b0, fwd_map(in_letter)} + {1'b0, pos_d};

        if (acc) begin
            valid_d = 1'b1;
            if (letter_ok) begin
                letter_d = (sum > 6'd26) ? 5'(sum - 6'd26) : sum[4:0];
                err_d    = 1'b0;
            end else begin
                letter_d = 5'd0;
                err_d    = 1'b1;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending output and turnover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q    <= 5'd0;
            valid_q  <= 1'b0;
            letter_q <= 5'd0;
            err_q    <= 1'b0;
            turn_q   <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            valid_q  <= valid_d;
            letter_q <= letter_d;
            err_q    <= err_d;
            turn_q   <= turn_d;
        end
    end

endmodule

// File: tb/tb_rotor2_fwd.sv
// Self-checking bench for rotor2_fwd: table-driven directed rows, back-pressure and reset
// sequences, exhaustive loopback through an inverse rotor, and randomized traffic against a model.
module tb_rotor2_fwd;

    localparam int FWD[27] = '{0, 6, 15, 11, 21, 4, 1, 26, 14, 17, 16, 24, 23, 2, 10, 9, 5, 8,
                               3, 13, 19, 7, 12, 18, 25, 20, 22};
    localparam int NOTCH_V = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, step_in, set_en, out_ready;
    logic [4:0] in_letter, set_pos;

    logic       in_ready[2], out_valid[2], out_err[2], turnover_out[2];
    logic [4:0] out_letter[2], pos[2];

    int checks   = 0;
    int failures = 0;

    // Model state, index 0 = DOUBLE_STEP on, index 1 = DOUBLE_STEP off.
    int m_pos[2], m_letter[2];
    bit m_valid[2], m_err[2], m_turn[2];

    always #5 clk = ~clk;

    rotor2_fwd #(.NOTCH(5'd4), .DOUBLE_STEP(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_letter(in_letter), .step_in(step_in), .set_en(set_en), .set_pos(set_pos),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_letter(out_letter[0]),
        .out_err(out_err[0]), .pos(pos[0]), .turnover_out(turnover_out[0])
    );

    rotor2_fwd #(.NOTCH(5'd4), .DOUBLE_STEP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_letter(in_letter), .step_in(step_in), .set_en(set_en), .set_pos(set_pos),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_letter(out_letter[1]),
        .out_err(out_err[1]), .pos(pos[1]), .turnover_out(turnover_out[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Inverse rotor: undo the position offset, then search the wiring table.
    function automatic int rotor2_inv(input int c, input int p);
        int t = c - p;
        while (t < 1) t += 26;
        for (int x = 1; x <= 26; x++) if (FWD[x] == t) return x;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 0; m_letter[k] = 0; m_valid[k] = 0; m_err[k] = 0; m_turn[k] = 0;
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            bit rdy = !m_valid[k] || out_ready;
            bit acc = in_valid && rdy;
            int np  = m_pos[k];
            m_turn[k] = 0;
            if (set_en) np = (set_pos > 25) ? 0 : int'(set_pos);
            else if (acc && (step_in || (k == 0 && m_pos[k] == NOTCH_V))) begin
                np = (m_pos[k] + 1) % 26;
                m_turn[k] = (m_pos[k] == NOTCH_V);
            end
            if (acc) begin
                m_valid[k] = 1;
                if (in_letter >= 1 && in_letter <= 26) begin
                    m_letter[k] = (FWD[in_letter] + np - 1) % 26 + 1;
                    m_err[k] = 0;
                end else begin
                    m_letter[k] = 0;
                    m_err[k] = 1;
                end
            end else if (out_ready) m_valid[k] = 0;
            m_pos[k] = np;
        end
    endtask

    task automatic model_compare();
        for (int k = 0; k < 2; k++) begin
            check(k == 0 ? "valid" : "valid_nods", out_valid[k], m_valid[k]);
            check(k == 0 ? "pos" : "pos_nods", pos[k], m_pos[k]);
            check(k == 0 ? "turnover" : "turnover_nods", turnover_out[k], m_turn[k]);
            if (m_valid[k]) begin
                check(k == 0 ? "letter" : "letter_nods", out_letter[k], m_letter[k]);
                check(k == 0 ? "err" : "err_nods", out_err[k], m_err[k]);
            end
        end
    endtask

    // One clock: in_ready checked before the edge, everything else 1ns after it.
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check("in_ready", in_ready[k], !m_valid[k] || out_ready);
        @(posedge clk);
        model_update();
        #1;
        model_compare();
    endtask

    task automatic drive(input bit se, input int sp, input bit iv, input int l, input bit st,
                         input bit rdy);
        set_en = se; set_pos = 5'(sp); in_valid = iv; in_letter = 5'(l);
        step_in = st; out_ready = rdy;
    endtask

    typedef struct {
        bit se; int sp; bit iv; int l; bit st; bit rdy;
        bit ev; int el; bit ee; int ep; bit et;
    } vec_t;

    vec_t tbl[10];
    int   held;

    initial begin
        tbl[0] = '{0, 0,  1, 1,  0, 1,  1, 6,  0, 0, 0};
        tbl[1] = '{1, 25, 1, 7,  0, 1,  1, 25, 0, 25, 0};
        tbl[2] = '{1, 30, 0, 0,  0, 1,  0, 0,  0, 0, 0};
        tbl[3] = '{1, 3,  0, 0,  0, 1,  0, 0,  0, 3, 0};
        tbl[4] = '{0, 0,  1, 1,  1, 1,  1, 10, 0, 4, 0};
        tbl[5] = '{0, 0,  1, 1,  0, 1,  1, 11, 0, 5, 1};
        tbl[6] = '{0, 0,  0, 0,  0, 1,  0, 0,  0, 5, 0};
        tbl[7] = '{0, 0,  1, 0,  1, 1,  1, 0,  1, 6, 0};
        tbl[8] = '{0, 0,  1, 27, 1, 1,  1, 0,  1, 7, 0};
        tbl[9] = '{0, 0,  1, 26, 0, 1,  1, 3,  0, 7, 0};

        drive(0, 0, 0, 0, 0, 1);
        rst_n = 1'b0;
        model_reset();
        #12;
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", out_valid[k], 0);
            check("rst_letter", out_letter[k], 0);
            check("rst_err", out_err[k], 0);
            check("rst_pos", pos[k], 0);
            check("rst_turn", turnover_out[k], 0);
            check("rst_in_ready", in_ready[k], 1);
        end
        @(negedge clk) rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].se, tbl[i].sp, tbl[i].iv, tbl[i].l, tbl[i].st, tbl[i].rdy);
            tick();
            check($sformatf("tbl%0d_valid", i), out_valid[0], tbl[i].ev);
            check($sformatf("tbl%0d_pos", i), pos[0], tbl[i].ep);
            check($sformatf("tbl%0d_turn", i), turnover_out[0], tbl[i].et);
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_letter", i), out_letter[0], tbl[i].el);
                check($sformatf("tbl%0d_err", i), out_err[0], tbl[i].ee);
            end
            // Without double-step the second letter at the notch leaves the rotor in place.
            if (i == 5) begin
                check("nods_pos", pos[1], 4);
                check("nods_letter", out_letter[1], 10);
                check("nods_turn", turnover_out[1], 0);
            end
        end

        // Back-pressure: position 10, letter 2 steps to 11 -> 15+11 = 26.
        drive(1, 10, 0, 0, 0, 1); tick();
        drive(0, 0, 1, 2, 1, 1); tick();
        check("bp_first", out_letter[0], 26);
        held = 0;
        drive(0, 0, 1, 3, 1, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_in_ready", in_ready[0], 0);
            check("bp_letter", out_letter[0], 26);
            check("bp_pos", pos[0], 11);
            if (out_valid[0]) held++;
        end
        check("bp_held_cycles", held, 5);
        drive(0, 0, 1, 3, 1, 1); tick();
        check("bp_rel1_letter", out_letter[0], 23);
        check("bp_rel1_pos", pos[0], 12);
        tick();
        check("bp_rel2_letter", out_letter[0], 24);
        check("bp_rel2_pos", pos[0], 13);

        // Exhaustive loopback through the inverse rotor.
        for (int p = 0; p < 26; p++) begin
            for (int l = 1; l <= 26; l++) begin
                drive(1, p, 1, l, 1'($urandom_range(0, 1)), 1);
                tick();
                check("loopback", rotor2_inv(out_letter[0], pos[0]), l);
            end
        end

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 31), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31), $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
            tick();
        end

        // Reset in the middle of a transfer clears outputs without waiting for a clock.
        drive(0, 0, 1, 5, 1, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check("mid_rst_valid", out_valid[k], 0);
            check("mid_rst_letter", out_letter[k], 0);
            check("mid_rst_err", out_err[k], 0);
            check("mid_rst_pos", pos[k], 0);
            check("mid_rst_turn", turnover_out[k], 0);
        end
        @(negedge clk) rst_n = 1'b1;
        drive(0, 0, 1, 1, 0, 1); tick();
        check("post_rst_letter", out_letter[0], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rotor2_fwd.md
# rotor2_fwd

Forward (keyboard-to-reflector) path of rotor 2, with its own stepping position register and a one-entry valid/ready output stage. For each accepted letter it updates the rotor position and enciphers the letter through rotor 2's forward wiring offset by that position. It signals turnover to rotor 3. It sits between rotor 1's forward stage and rotor 3, and is the exact functional inverse of the rotor 2 reflection-path block at the same position.

## Interface
- NOTCH, 5'd4: position index (0..25) from which a step produces turnover to rotor 3.
- DOUBLE_STEP, 1: 1 means the rotor steps itself on any accepted letter while pos == NOTCH (Enigma double-step); 0 disables this.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_letter is valid this cycle.
- in_ready  out  1  stage can accept; combinational, equals !out_valid || out_ready.
- in_letter  in  5  letter, 1..26 = A..Z.
- step_in  in  1  turnover from rotor 1; sampled only on an accepted transfer.
- set_en  in  1  load position from set_pos.
- set_pos  in  5  new position, 0..25.
- out_valid  out  1  out_letter/out_err valid.
- out_ready  in  1  downstream accepts.
- out_letter  out  5  enciphered letter 1..26, or 0 on error.
- out_err  out  1  in_letter was out of range (0 or 27..31).
- pos  out  5  current rotor position 0..25 (registered).
- turnover_out  out  1  one-cycle pulse to rotor 3.

## Operation
- Forward wiring f, written as letter -> value: 1->6, 2->15, 3->11, 4->21, 5->4, 6->1, 7->26, 8->14, 9->17, 10->16, 11->24, 12->23, 13->2, 14->10, 15->9, 16->5, 17->8, 18->3, 19->13, 20->19, 21->7, 22->12, 23->18, 24->25, 25->20, 26->22.
- Accepted transfer (acc) = in_valid && in_ready.
- Next position np:
  - set_en = 1: np = set_pos, or 0 if set_pos > 25. set_en has priority over all stepping.
  - acc = 1 and (step_in = 1, or DOUBLE_STEP = 1 and pos == NOTCH): np = pos + 1, wrapping 25 -> 0. A simultaneous step_in and double-step condition produces a single step.
  - Otherwise np = pos.
- set_en is honoured on any cycle, with or without acc.
- On acc:
  - s = f(in_letter) + np, a 6-bit value in the range 1..51.
  - out_letter <= (s > 26) ? s - 26 : s.
  - out_err <= 0, and out_valid <= 1.
- Invalid in_letter (0 or 27..31) on acc:
  - out_letter <= 0, out_err <= 1, out_valid <= 1.
  - Stepping still applies.
- When out_valid && out_ready && !acc: out_valid <= 0.
- The inverse property is required: rotor2_inv(out_letter, np) == in_letter for every valid letter and every position.
- turnover_out <= 1 for exactly one cycle after an acc in which a step (not a load) moved pos from NOTCH to NOTCH+1.

## Timing
- Reset (async assert, released synchronously to clk):
  - pos = 0, out_valid = 0, out_letter = 0, out_err = 0, turnover_out = 0.
  - in_ready = 1 after reset.
- Latency: one cycle. A letter accepted at edge N appears on out_letter/out_valid after edge N. pos updates at the same edge N.
- Throughput: one letter per cycle while out_ready = 1.
- Back-pressure: while out_valid = 1 and out_ready = 0:
  - out_letter, out_err and out_valid hold stable.
  - in_ready = 0, so there is no acc.
  - pos changes only through set_en.
- A simultaneous output drain and new acc in the same cycle keeps out_valid = 1 with the new data (no bubble).
- Reset asserted mid-transfer discards the pending output immediately. No turnover pulse is generated.
- An in_valid that is not accepted must not step the rotor, even if step_in = 1.

## Test plan
- Reset, pos = 0, in_letter = 1, acc -> next cycle out_letter = 6, out_valid = 1, out_err = 0, pos = 0.
- set_en with set_pos = 25, then in_letter = 7 -> s = 26 + 25 = 51, so out_letter = 25. Then set_pos = 30 -> pos = 0.
- Double-step sequence, pos = 3:
  - Letter 1 with step_in = 1 -> pos = 4, out_letter = 10, turnover_out = 0.
  - Next letter 1 with step_in = 0 -> pos = 5, out_letter = 11, turnover_out = 1 for one cycle.
  - Repeat with DOUBLE_STEP = 0 -> second letter gives pos = 4, out_letter = 10, no turnover.
- Back-pressure:
  - Hold out_ready = 0 for 5 cycles while in_valid = 1 and step_in = 1 -> out_letter frozen, in_ready = 0, pos unchanged.
  - Release out_ready -> exactly one new letter accepted per cycle and one step each.
- in_letter = 0 and in_letter = 27 -> out_letter = 0, out_err = 1. pos still steps when step_in = 1.
- Exhaustive loopback: for all positions 0..25 and letters 1..26, feed out_letter and the post-step pos into rotor2_inv -> equals the original letter. Also assert rst_n mid-stream -> all outputs 0 asynchronously.
